i2c_req_arbiter: RTL
====================

// Module: i2c_req_arbiter
// PURPOSE
//  Shares the single I2C master (wr/addr/din/datard/done command port) among N_REQ
//  requesters (e.g. config FSM, sensor poller, host bridge). Round-robin arbitration,
//  one outstanding transaction, command latched and held stable for the master.
//  Per-transaction watchdog returns an error if the master never signals done.
// PARAMETERS
//  N_REQ    4     number of requesters (>=2)
//  TIMEOUT  4096  max cycles to wait for m_done, counted from m_start rising (>=2)
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  req        in   N_REQ    per-requester level request, held until its rsp_valid
//  req_wr     in   N_REQ    1=write, 0=read, valid while req high
//  req_addr   in   7*N_REQ  7-bit slave address, slice i = [7i+6:7i]
//  req_din    in   8*N_REQ  write data, slice i = [8i+7:8i]
//  gnt        out  N_REQ    one-hot owner of master, ISSUE through RESP
//  rsp_valid  out  N_REQ    one-cycle pulse to owner: transaction finished
//  rsp_err    out  1        qualifies rsp_valid: 1 = timeout
//  rsp_data   out  8        read data, valid with rsp_valid
//  busy       out  1        1 whenever state != IDLE
//  m_start    out  1        one-cycle pulse launching master transaction
//  m_wr       out  1        latched command to master, stable during WAIT
//  m_addr     out  7        latched slave address
//  m_din      out  8        latched write data
//  m_datard   in   8        master read data, valid with m_done
//  m_done     in   1        master completion pulse
// BEHAVIOUR
//  - Reset: state IDLE; gnt, rsp_valid, rsp_err, busy, m_start, m_wr = 0;
//    m_addr = 0, m_din = 0, rsp_data = 0; rr pointer = N_REQ-1 (req0 has top priority).
//    Reset mid-transaction aborts silently: no rsp_valid.
//  - All outputs registered. States: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: if |req, winner = first set bit scanning from ptr+1 modulo N_REQ.
//    Edge: latch winner's wr/addr/din into m_*, gnt[winner]=1, m_start=1,
//    cnt=0, -> WAIT. m_done in IDLE ignored (stray).
//  - WAIT: m_start drops after 1 cycle. Per edge: if m_done -> rsp_data=m_datard,
//    rsp_err=0, -> RESP; else if cnt==TIMEOUT-1 -> rsp_data=0, rsp_err=1, -> RESP;
//    else cnt++. m_done and timeout same edge: done wins.
//    cnt width $clog2(TIMEOUT); never wraps.
//  - Request inputs ignored outside IDLE; m_wr/m_addr/m_din do not change in WAIT.
//  - RESP (1 cycle): rsp_valid[winner]=1, gnt held; edge: ptr=winner, gnt=0,
//    rsp_valid=0, rsp_err=0, -> IDLE. rsp_data holds until next response.
//  - Requester clears req on the edge that samples its rsp_valid; req still high
//    in IDLE is a new request. Minimum turnaround IDLE->IDLE: 3 cycles + master time.
//  - Latency: req sampled at edge E0 -> m_start high cycle after E0; m_done sampled
//    at Ek -> rsp_valid high cycle after Ek. Timeout: rsp_valid TIMEOUT cycles after m_start.
// TESTING
//  - req[0], wr=1, addr=0x50, din=0xA5; m_done 20 cycles after m_start ->
//    m_start 1 cycle, m_addr=0x50, m_din=0xA5, m_wr=1; rsp_valid[0], rsp_err=0 next cycle.
//  - Read: req[2] wr=0, addr=0x23; m_done with m_datard=0x3C ->
//    rsp_valid[2], rsp_data=0x3C, gnt=4'b0100 throughout.
//  - req=4'b1111 after reset, req0 re-raised after its response ->
//    grant order 0,1,2,3,0; never two gnt bits set.
//  - TIMEOUT=16, no m_done -> rsp_valid 16 cycles after m_start, rsp_err=1,
//    rsp_data=0x00; next request serviced normally.
//  - rst high mid-WAIT -> all outputs 0 next cycle, no rsp_valid;
//    then req=4'b0110 -> req1 granted first.
//  - Stray m_done in IDLE and req_addr toggling during WAIT -> no state change,
//    no extra rsp_valid, m_addr stable.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master command port among N_REQ requesters,
// one transaction in flight, command latched for the master, watchdog on m_done.
module i2c_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_wr,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_din,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_err,
  output logic [7:0]           rsp_data,
  output logic                 busy,
  output logic                 m_start,
  output logic                 m_wr,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_din,
  input  logic [7:0]           m_datard,
  input  logic                 m_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic               m_start_q, m_start_d;
  logic               m_wr_q, m_wr_d;
  logic [6:0]         m_addr_q, m_addr_d;
  logic [7:0]         m_din_q, m_din_d;

  logic [PW-1:0]      rr_win;
  logic               rr_found;

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    rr_win   = ptr_q;
    rr_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!rr_found && req[PW'(idx)]) begin
        rr_found = 1'b1;
        rr_win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    m_start_d   = 1'b0;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_din_d     = m_din_q;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          win_d         = rr_win;
          gnt_d         = '0;
          gnt_d[rr_win] = 1'b1;
          m_start_d     = 1'b1;
          m_wr_d        = req_wr[rr_win];
          m_addr_d      = req_addr[7*int'(rr_win) +: 7];
          m_din_d       = req_din[8*int'(rr_win) +: 8];
          cnt_d         = '0;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion takes precedence over a watchdog expiry on the same edge.
        if (m_done) begin
          rsp_data_d  = m_datard;
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_q;
          state_d     = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        ptr_d     = win_q;
        gnt_d     = '0;
        rsp_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PW'(N_REQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= 7'h00;
      m_din_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      m_start_q   <= m_start_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_din_q     <= m_din_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign m_start   = m_start_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_din     = m_din_q;

endmodule
